// File: rtl/sd_arbiter.sv
// ============================================================================
// sd_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Shares one MiSTer-style SD block channel (sd_lba / sd_rd / sd_wr /
//   sd_ack / sd_buff_wr / sd_buff_din) between two clients:
//   client 0 = FDC, client 1 = SDC.
//   A granted client keeps the channel until its block transfer is complete.
//   When both clients request in the same idle cycle, the client that was
//   not served last wins (round-robin).
//   All registers update on the FALLING edge of CLK.
//
// Optional feature (macro SD_ARB_TIMEOUT_EN):
//   When defined, a TIMEOUT_W-bit watchdog runs while a transfer is
//   outstanding (ISSUE/XFER). If it reaches all-ones, the request is
//   withdrawn, timeout pulses for one cycle and the FSM closes the
//   transfer through DONE. When the macro is undefined there is no
//   watchdog, timeout is tied to 0 and a transfer waits indefinitely.
//
// Handshake:
//   A client raises req_rd or req_wr (level) and keeps it high until it
//   sees its cli_ack bit rise; it then drops the request. A request that is
//   still high while the arbiter is idle starts a new transfer.
//   The SD side sees sd_rd/sd_wr high from the grant until the first cycle
//   in which sd_ack is 1. The transfer is over when sd_ack falls.
//
// Ports:
//   CLK            in   1   system clock (falling edge active)
//   RESET_N        in   1   asynchronous, active-low reset
//   req_rd         in   2   per-client read request (bit n = client n)
//   req_wr         in   2   per-client write request
//   req_lba0/1     in  32   per-client block address
//   cli_buff_din0/1 in  8   per-client sector buffer read data
//   cli_ack        out  2   sd_ack routed to the granted client
//   cli_buff_wr    out  2   sd_buff_wr routed to the granted client
//   sd_lba         out 32   latched block address of the granted client
//   sd_rd, sd_wr   out  1   read / write request to the SD channel
//   sd_ack         in   1   SD channel acknowledge
//   sd_buff_wr     in   1   SD channel buffer write strobe
//   sd_buff_din    out  8   granted client's buffer data (0 when no grant)
//   grant          out  2   one-hot granted client, or 0
//   busy           out  1   high from ISSUE through DONE
//   timeout        out  1   one-cycle watchdog abort pulse
//   dbg_state      out  2   current FSM state (IDLE=0 ISSUE=1 XFER=2 DONE=3)
// ============================================================================
module sd_arbiter #(
    parameter int TIMEOUT_W = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,

    // Client side
    input  logic [1:0]  req_rd,
    input  logic [1:0]  req_wr,
    input  logic [31:0] req_lba0,
    input  logic [31:0] req_lba1,
    input  logic [7:0]  cli_buff_din0,
    input  logic [7:0]  cli_buff_din1,
    output logic [1:0]  cli_ack,
    output logic [1:0]  cli_buff_wr,

    // Shared SD block channel
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,

    // Status
    output logic [1:0]  grant,
    output logic        busy,
    output logic        timeout,
    output logic [1:0]  dbg_state
);

    // ------------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [1:0]  r_grant;
    logic [31:0] r_lba;
    logic        r_rd;
    logic        r_wr;
    logic        r_busy;
    logic        r_ack_d;
    // Index of the client served most recently; resets to 1 so that
    // client 0 wins the very first contended arbitration.
    logic        r_last;

    // ------------------------------------------------------------------------
    // Arbitration (combinational, only consumed in IDLE)
    // ------------------------------------------------------------------------
    logic [1:0]  w_req;
    logic        w_pick;
    logic        w_pick_rd;
    logic [31:0] w_pick_lba;
    logic [1:0]  w_pick_grant;
    logic        w_ack_fall;

    assign w_req = req_rd | req_wr;

    always_comb begin
        w_pick = 1'b0;
        if (w_req == 2'b11) begin
            // Contention: the client that was not served last goes first.
            w_pick = ~r_last;
        end else begin
            // Single requester (or none): bit 1 set means client 1.
            w_pick = w_req[1];
        end
    end

    // A client raising both request lines is served as a read.
    assign w_pick_rd    = w_pick ? req_rd[1] : req_rd[0];
    assign w_pick_lba   = w_pick ? req_lba1 : req_lba0;
    assign w_pick_grant = w_pick ? 2'b10 : 2'b01;

    // End of transfer: ack was high last cycle and is low now.
    assign w_ack_fall = r_ack_d & ~sd_ack;

`ifdef SD_ARB_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------------
    logic [TIMEOUT_W-1:0] r_wd;
    logic [TIMEOUT_W-1:0] w_wd_inc;
    logic                 w_wd_expire;
    logic                 r_timeout;

    assign w_wd_inc = r_wd + 1'b1;
    // Abort on the edge at which the counter reaches all-ones, i.e. after
    // 2**TIMEOUT_W - 1 cycles spent in ISSUE/XFER.
    assign w_wd_expire = &w_wd_inc;
`endif

    // ------------------------------------------------------------------------
    // Main FSM, falling-edge clocked
    // ------------------------------------------------------------------------
    always_ff @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= ST_IDLE;
            r_grant   <= 2'b00;
            r_lba     <= 32'd0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_busy    <= 1'b0;
            r_ack_d   <= 1'b0;
            r_last    <= 1'b1;
`ifdef SD_ARB_TIMEOUT_EN
            r_wd      <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_ack_d <= sd_ack;

            unique case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_grant <= w_pick_grant;
                        r_lba   <= w_pick_lba;
                        r_rd    <= w_pick_rd;
                        r_wr    <= ~w_pick_rd;
                        r_busy  <= 1'b1;
                        r_state <= ST_ISSUE;
`ifdef SD_ARB_TIMEOUT_EN
                        r_wd    <= '0;
`endif
                    end
                end

                ST_ISSUE: begin
                    if (sd_ack) begin
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_state <= ST_XFER;
                    end
`ifdef SD_ARB_TIMEOUT_EN
                    else if (w_wd_expire) begin
                        r_rd      <= 1'b0;
                        r_wr      <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                    r_wd <= w_wd_inc;
`endif
                end

                ST_XFER: begin
                    if (w_ack_fall) begin
                        r_state <= ST_DONE;
                    end
`ifdef SD_ARB_TIMEOUT_EN
                    else if (w_wd_expire) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                    r_wd <= w_wd_inc;
`endif
                end

                ST_DONE: begin
                    // Requests are not looked at here; a request that is
                    // still high is picked up once back in IDLE.
                    r_last  <= r_grant[1];
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
`ifdef SD_ARB_TIMEOUT_EN
                    r_timeout <= 1'b0;
`endif
                end

                default: begin
                    r_grant <= 2'b00;
                    r_rd    <= 1'b0;
                    r_wr    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Routing muxes selected by grant. With grant == 0 (idle, or right after
    // reset) nothing is routed to either client.
    // ------------------------------------------------------------------------
    always_comb begin
        cli_ack     = 2'b00;
        cli_buff_wr = 2'b00;
        sd_buff_din = 8'd0;
        if (r_grant[0]) begin
            cli_ack[0]     = sd_ack;
            cli_buff_wr[0] = sd_buff_wr;
            sd_buff_din    = cli_buff_din0;
        end else if (r_grant[1]) begin
            cli_ack[1]     = sd_ack;
            cli_buff_wr[1] = sd_buff_wr;
            sd_buff_din    = cli_buff_din1;
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign sd_lba    = r_lba;
    assign sd_rd     = r_rd;
    assign sd_wr     = r_wr;
    assign grant     = r_grant;
    assign busy      = r_busy;
    assign dbg_state = r_state;

`ifdef SD_ARB_TIMEOUT_EN
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: doc/sd_arbiter.md
SD_ARBITER -- requirements
Module: sd_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_W, default 16, giving the watchdog counter width in bits.
REQ-002 The block SHALL have port CLK  in  1  system clock; all registers update on the falling edge.
REQ-003 The block SHALL have port RESET_N  in  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port req_rd  in  2  per-client read request, level, bit n = client n (0 = FDC, 1 = SDC).
REQ-005 The block SHALL have port req_wr  in  2  per-client write request, level.
REQ-006 The block SHALL have ports req_lba0 and req_lba1  in  32 each  per-client block address.
REQ-007 The block SHALL have port cli_buff_din0 and cli_buff_din1  in  8 each  per-client sector buffer read data.
REQ-008 The block SHALL have port cli_ack  out  2  sd_ack routed to the granted client; other bit 0.
REQ-009 The block SHALL have port cli_buff_wr  out  2  sd_buff_wr routed to the granted client; other bit 0.
REQ-010 The block SHALL have ports sd_lba  out  32,  sd_rd  out  1,  sd_wr  out  1,  sd_ack  in  1,  sd_buff_wr  in  1,  sd_buff_din  out  8  single shared MiSTer block channel.
REQ-011 The block SHALL have ports grant  out  2 (one-hot or zero), busy  out  1, and timeout  out  1 (one-cycle abort pulse).

Function
REQ-012 FSM states SHALL be IDLE, ISSUE, XFER, DONE.
REQ-013 IDLE: when any req_rd|req_wr bit is set, register grant, latch that client's lba into sd_lba, latch op type, and go to ISSUE next cycle; busy=1 from ISSUE through DONE.
REQ-014 When both clients request in the same IDLE cycle, the client not served last SHALL win (round-robin); a single requester always wins.
REQ-015 A client asserting req_rd and req_wr together SHALL be served as a read.
REQ-016 ISSUE: sd_rd (read) or sd_wr (write) SHALL be 1; on the cycle sd_ack=1, deassert it and go to XFER.
REQ-017 XFER: on the falling edge of sd_ack (registered ack_d=1, sd_ack=0), go to DONE.
REQ-018 DONE: lasting one cycle, clear grant, record the served client as last-served, and return to IDLE; requests SHALL be ignored in DONE.
REQ-019 Clients SHALL drop their request on seeing cli_ack rise; a request still high in IDLE starts a new transfer.
REQ-020 cli_ack, cli_buff_wr, and sd_buff_din SHALL be combinational muxes selected by grant; sd_buff_din SHALL be 0 when grant=0.
REQ-021 sd_lba SHALL hold its value from latch until the next grant; request inputs changing during ISSUE/XFER SHALL have no effect.

Reset
REQ-022 While RESET_N=0: state=IDLE, grant=0, sd_rd=0, sd_wr=0, sd_lba=0, busy=0, timeout=0, ack_d=0, last-served=1 (client 0 preferred first), watchdog=0.
REQ-023 Reset mid-transfer SHALL abort immediately; no ack or buffer write SHALL be routed afterwards until a new grant.

Configuration
REQ-024 With SD_ARB_TIMEOUT_EN defined, a TIMEOUT_W-bit watchdog SHALL clear on entering ISSUE, increment each cycle in ISSUE/XFER, and at all-ones force sd_rd=sd_wr=0, pulse timeout for one cycle, and go to DONE.
REQ-025 Without SD_ARB_TIMEOUT_EN, no watchdog SHALL exist, timeout SHALL be tied 0, and ISSUE/XFER SHALL wait indefinitely.

Verification
REQ-026 Client 1 req_rd with lba 0x00001234 -> grant=2'b10, sd_lba=0x00001234, sd_rd=1 until sd_ack; cli_ack[1] follows sd_ack; IDLE after ack falls.
REQ-027 Both clients req_rd in the same cycle after reset -> client 0 served first, then client 1; grant never 2'b11.
REQ-028 Client 0 req_wr; sd_buff_wr pulses with ack high -> cli_buff_wr[0] pulses, cli_buff_wr[1]=0; sd_buff_din equals cli_buff_din0.
REQ-029 RESET_N low during XFER -> all outputs 0 next falling edge; subsequent request is granted normally.
REQ-030 SD_ARB_TIMEOUT_EN with TIMEOUT_W=4, sd_ack held 0 -> sd_rd drops and timeout pulses 15 cycles after entering ISSUE; without the macro, sd_rd stays 1.
